// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - registered program-counter generator with redirect tracking
//
// Holds the architectural PC and computes the next fetch address from the
// NPC_* operation, branch condition, stall, trap redirect and target alignment.
// Optional redirect trace buffer is compiled in when PC_TRACE_EN is defined;
// without it the trace outputs are tied to zero and the ports remain present.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   stall_i           hold PC this cycle
//   npc_op_i          NPC_PLUS4 / NPC_BRANCH / NPC_JUMP / NPC_JALR
//   br_taken_i        branch condition, qualifies NPC_BRANCH
//   imm_i             sign-extended offset
//   jalr_base_i       rs1 value for JALR
//   trap_i            trap redirect request
//   trap_vec_i        trap handler address
//   pc_o              current PC (registered)
//   npc_o             next PC (combinational)
//   link_o            pc_o + 4
//   misalign_o        one-cycle pulse after a misaligned redirect attempt
//   bad_addr_o        captured misaligned target
//   redir_cnt_o       saturating count of committed redirects
//   trace_idx_i       trace read index, 0 = most recent
//   trace_src_o       trace entry source PC
//   trace_dst_o       trace entry target PC
//   trace_cnt_o       number of valid trace entries
module pc_gen_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall_i,
    input  logic [2:0]                     npc_op_i,
    input  logic                           br_taken_i,
    input  logic [XLEN-1:0]                imm_i,
    input  logic [XLEN-1:0]                jalr_base_i,
    input  logic                           trap_i,
    input  logic [XLEN-1:0]                trap_vec_i,
    output logic [XLEN-1:0]                pc_o,
    output logic [XLEN-1:0]                npc_o,
    output logic [XLEN-1:0]                link_o,
    output logic                           misalign_o,
    output logic [XLEN-1:0]                bad_addr_o,
    output logic [15:0]                    redir_cnt_o,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
    output logic [XLEN-1:0]                trace_src_o,
    output logic [XLEN-1:0]                trace_dst_o,
    output logic [$clog2(TRACE_DEPTH):0]   trace_cnt_o
);

    localparam int IW = $clog2(TRACE_DEPTH);

    // Encodings shared with ctrl_encode_def.v
    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            is_ctl;
    logic            misaligned;
    logic            commit_ctl;
    logic            redirect;
    logic [XLEN-1:0] npc;

    logic            misalign_q;
    logic [XLEN-1:0] bad_addr_q;
    logic [15:0]     redir_cnt_q;

    // ------------------------------------------------------------------
    // Target computation
    // ------------------------------------------------------------------
    always_comb begin
        pc_plus4    = pc_q + FOUR;
        pc_plus_imm = pc_q + imm_i;
        jalr_sum    = jalr_base_i + imm_i;
        target      = pc_plus4;
        is_ctl      = 1'b0;
        case (npc_op_i)
            NPC_PLUS4: begin
                target = pc_plus4;
                is_ctl = 1'b0;
            end
            NPC_BRANCH: begin
                target = br_taken_i ? pc_plus_imm : pc_plus4;
                is_ctl = br_taken_i;
            end
            NPC_JUMP: begin
                target = pc_plus_imm;
                is_ctl = 1'b1;
            end
            NPC_JALR: begin
                target = {jalr_sum[XLEN-1:1], 1'b0};
                is_ctl = 1'b1;
            end
            default: begin
                target = pc_plus4;
                is_ctl = 1'b0;
            end
        endcase
    end

    // Sequential PLUS4 (and untaken branches) are always word aligned when
    // pc is, so only control transfers are alignment-checked.
    assign misaligned = is_ctl && (target[1:0] != 2'b00);

    // A control transfer commits only when nothing of higher priority wins.
    assign commit_ctl = !trap_i && !stall_i && !misaligned && is_ctl;
    assign redirect   = trap_i || commit_ctl;

    always_comb begin
        if (trap_i) begin
            npc = trap_vec_i;
        end else if (stall_i || misaligned) begin
            npc = pc_q;
        end else begin
            npc = target;
        end
    end

    // ------------------------------------------------------------------
    // PC, misalignment capture and redirect counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            misalign_q  <= 1'b0;
            bad_addr_q  <= '0;
            redir_cnt_q <= '0;
        end else begin
            pc_q       <= npc;
            // Pulse only when the misaligned transfer was actually the
            // winning request this edge.
            misalign_q <= !trap_i && !stall_i && misaligned;
            if (!trap_i && !stall_i && misaligned) begin
                bad_addr_q <= target;
            end
            if (redirect && (redir_cnt_q != 16'hFFFF)) begin
                redir_cnt_q <= redir_cnt_q + 16'd1;
            end
        end
    end

    assign pc_o        = pc_q;
    assign npc_o       = npc;
    assign link_o      = pc_plus4;
    assign misalign_o  = misalign_q;
    assign bad_addr_o  = bad_addr_q;
    assign redir_cnt_o = redir_cnt_q;

    // ------------------------------------------------------------------
    // Redirect trace
    // ------------------------------------------------------------------
`ifdef PC_TRACE_EN
    logic [XLEN-1:0] tr_src [TRACE_DEPTH];
    logic [XLEN-1:0] tr_dst [TRACE_DEPTH];
    logic [IW-1:0]   wr_ptr;
    logic [IW:0]     tr_cnt;
    logic [IW-1:0]   rd_ptr;
    logic            rd_valid;

    // Entry storage is deliberately not reset; validity comes from tr_cnt.
    always_ff @(posedge clk) begin
        if (!rst && redirect) begin
            tr_src[wr_ptr] <= pc_q;
            tr_dst[wr_ptr] <= npc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            tr_cnt <= '0;
        end else if (redirect) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (tr_cnt != (IW+1)'(TRACE_DEPTH)) begin
                tr_cnt <= tr_cnt + 1'b1;
            end
        end
    end

    // Most recent entry sits just behind the write pointer; the
    // subtraction wraps naturally because TRACE_DEPTH is a power of 2.
    assign rd_ptr   = wr_ptr - IW'(1) - trace_idx_i;
    assign rd_valid = ({1'b0, trace_idx_i} < tr_cnt);

    assign trace_src_o = rd_valid ? tr_src[rd_ptr] : '0;
    assign trace_dst_o = rd_valid ? tr_dst[rd_ptr] : '0;
    assign trace_cnt_o = tr_cnt;
`else
    logic unused_trace;
    assign unused_trace = ^trace_idx_i;

    assign trace_src_o = '0;
    assign trace_dst_o = '0;
    assign trace_cnt_o = '0;
`endif

endmodule
